// File: rtl/snap_ctrl_pkg.sv
// Shared definitions for the 10GbE TX snapshot capture sequencer:
// FSM states and bit positions of the software control/status words.
package snap_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TRIG = 2'd1,
        CAPTURE   = 2'd2,
        DONE      = 2'd3
    } snap_state_e;

    localparam int CTRL_ARM        = 0;
    localparam int CTRL_TRIG_EN    = 1;
    localparam int CTRL_VALID_GATE = 2;
    localparam int CTRL_ABORT      = 3;

    localparam int ST_DONE = 31;
    localparam int ST_BUSY = 30;

endpackage

// File: rtl/snap_edge_det.sv
// Rising-edge detector for a software-register bit: the previous level is
// registered and the pulse is high for the one cycle the bit goes 0 -> 1.
module snap_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/snap_capture_ctrl.sv
// Snapshot buffer sequencer: arms on a software edge, optionally waits for a
// trigger, then writes qualified TX words into the BRAM until it is full.
//
//   state     | meaning
//   IDLE      | not armed; counter holds the last (possibly partial) count
//   WAIT_TRIG | armed, discarding samples until a qualified trigger
//   CAPTURE   | writing one word per qualified cycle
//   DONE      | buffer full; holds until re-armed
module snap_capture_ctrl
    import snap_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
) (
    input  logic              user_clk,
    input  logic              user_rst,
    input  logic [31:0]       ctrl_in,
    input  logic [DATA_W-1:0] din_data,
    input  logic              din_valid,
    input  logic              din_trig,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_data,
    output logic              bram_we,
    output logic [31:0]       status_out
);

    localparam logic [ADDR_W:0] LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};

    snap_state_e       state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [31:0]       status_q, status_d;

    logic              arm_rise;
    logic              qual;
    logic              wr;
    logic [ADDR_W-1:0] wr_addr;
    logic              unused_ctrl;

    assign unused_ctrl = ^ctrl_in[31:4];

    snap_edge_det u_arm_edge (
        .clk    (user_clk),
        .rst    (user_rst),
        .sig_i  (ctrl_in[CTRL_ARM]),
        .rise_o (arm_rise)
    );

    assign qual = ctrl_in[CTRL_VALID_GATE] ? din_valid : 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr      = 1'b0;
        wr_addr = cnt_q[ADDR_W-1:0];

        // Abort wins over a simultaneous arm edge and keeps the partial count.
        if (ctrl_in[CTRL_ABORT]) begin
            state_d = IDLE;
        end else if (arm_rise) begin
            cnt_d   = '0;
            state_d = ctrl_in[CTRL_TRIG_EN] ? WAIT_TRIG : CAPTURE;
        end else begin
            case (state_q)
                WAIT_TRIG: begin
                    if (qual && din_trig) begin
                        wr      = 1'b1;
                        wr_addr = '0;
                        cnt_d   = {{ADDR_W{1'b0}}, 1'b1};
                        state_d = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (qual) begin
                        wr    = 1'b1;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == LAST_ADDR) begin
                            state_d = DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        status_d              = '0;
        status_d[ADDR_W:0]    = cnt_d;
        status_d[ST_DONE]     = (state_d == DONE);
        status_d[ST_BUSY]     = (state_d == WAIT_TRIG) || (state_d == CAPTURE);
    end

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= wr;
            status_q <= status_d;
            if (wr) begin
                addr_q <= wr_addr;
                data_q <= din_data;
            end
        end
    end

    assign bram_we    = we_q;
    assign bram_addr  = addr_q;
    assign bram_data  = data_q;
    assign status_out = status_q;

endmodule

// File: tb/tb_snap_capture_ctrl.sv
// Randomized bench for snap_capture_ctrl against a cycle-level behavioural
// model of the capture rules (phase + word count + expected write port).
module tb_snap_capture_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 64;
    localparam int DEPTH = 1 << AW;

    logic          user_clk = 1'b0;
    logic          user_rst;
    logic [31:0]   ctrl_in;
    logic [DW-1:0] din_data;
    logic          din_valid;
    logic          din_trig;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_data;
    logic          bram_we;
    logic [31:0]   status_out;

    snap_capture_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .user_clk   (user_clk),
        .user_rst   (user_rst),
        .ctrl_in    (ctrl_in),
        .din_data   (din_data),
        .din_valid  (din_valid),
        .din_trig   (din_trig),
        .bram_addr  (bram_addr),
        .bram_data  (bram_data),
        .bram_we    (bram_we),
        .status_out (status_out)
    );

    always #5 user_clk = ~user_clk;

    int n_chk = 0;
    int n_err = 0;

    // Model: phase 0 idle, 1 waiting for trigger, 2 capturing, 3 full.
    int          m_phase;
    int          m_cnt;
    bit          m_arm_prev;
    bit          m_we;
    int          m_addr;
    logic [DW-1:0] m_data;
    int          m_writes;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = 32'(m_cnt);
        if (m_phase == 3) s[31] = 1'b1;
        if (m_phase == 1 || m_phase == 2) s[30] = 1'b1;
        return s;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_arm_prev = 0;
        m_we = 0; m_addr = 0; m_data = '0;
    endtask

    task automatic model_write(input int a);
        m_we = 1; m_addr = a; m_data = din_data; m_writes++;
    endtask

    task automatic model_edge();
        bit arm, rise, qual;
        arm  = ctrl_in[0];
        rise = arm && !m_arm_prev;
        m_arm_prev = arm;
        qual = ctrl_in[2] ? din_valid : 1'b1;
        m_we = 0;
        if (ctrl_in[3]) begin
            m_phase = 0;
        end else if (rise) begin
            m_cnt   = 0;
            m_phase = ctrl_in[1] ? 1 : 2;
        end else if (m_phase == 1 && qual && din_trig) begin
            model_write(0);
            m_cnt   = 1;
            m_phase = 2;
        end else if (m_phase == 2 && qual) begin
            model_write(m_cnt);
            m_cnt++;
            if (m_cnt == DEPTH) m_phase = 3;
        end
    endtask

    task automatic step();
        @(posedge user_clk);
        model_edge();
        #1;
        chk("we", 64'(bram_we), 64'(m_we));
        chk("addr", 64'(bram_addr), 64'(m_addr));
        chk("data", bram_data, m_data);
        chk("status", 64'(status_out), 64'(m_status()));
    endtask

    task automatic arm(input logic [31:0] c);
        ctrl_in = 32'h0;
        step();
        ctrl_in = c;
        step();
    endtask

    initial begin
        int w0;
        int seq;
        user_rst = 1'b1;
        ctrl_in = 32'h0; din_data = '0; din_valid = 1'b0; din_trig = 1'b0;
        model_reset();
        m_writes = 0;
        #12;
        chk("rst_we", 64'(bram_we), 64'h0);
        chk("rst_status", 64'(status_out), 64'h0);
        @(negedge user_clk);
        user_rst = 1'b0;

        // 1: immediate capture with incrementing data
        din_valid = 1'b1;
        din_data  = 64'h0F;
        w0 = m_writes;
        arm(32'h1);
        for (int i = 0; i < DEPTH; i++) begin
            din_data = 64'(32'h10 + i);
            step();
            chk("s1_addr", 64'(bram_addr), 64'(i));
            chk("s1_data", bram_data, 64'(32'h10 + i));
        end
        chk("s1_status", 64'(status_out), 64'h8000_0010);
        for (int i = 0; i < 3; i++) step();
        chk("s1_nwr", 64'(m_writes - w0), 64'(DEPTH));
        chk("s1_we_after", 64'(bram_we), 64'h0);

        // 5: re-arm from DONE
        arm(32'h1);
        chk("s5_busy", 64'(status_out), 64'h4000_0000);
        din_data = 64'h55;
        step();
        chk("s5_addr0", 64'(bram_addr), 64'h0);
        chk("s5_we", 64'(bram_we), 64'h1);
        for (int i = 0; i < DEPTH + 2; i++) begin
            din_data = {$urandom, $urandom};
            step();
        end

        // 2: triggered, gated
        din_trig = 1'b0;
        din_valid = 1'b1;
        w0 = m_writes;
        arm(32'h7);
        for (int i = 0; i < 5; i++) begin
            din_data = {$urandom, $urandom};
            step();
        end
        chk("s2_pretrig", 64'(m_writes - w0), 64'h0);
        din_trig = 1'b1;
        din_data = 64'hAA;
        step();
        chk("s2_first_addr", 64'(bram_addr), 64'h0);
        chk("s2_first_data", bram_data, 64'hAA);
        din_trig = 1'b0;
        for (int i = 0; i < 200 && m_phase != 3; i++) begin
            din_valid = 1'($urandom);
            din_trig  = 1'($urandom);
            din_data  = {$urandom, $urandom};
            step();
        end
        chk("s2_nwr", 64'(m_writes - w0), 64'(DEPTH));
        chk("s2_done", 64'(status_out[31]), 64'h1);

        // 3: valid toggling under the gate
        din_trig = 1'b0;
        w0 = m_writes;
        seq = 0;
        arm(32'h5);
        for (int i = 0; i < 4 * DEPTH; i++) begin
            din_valid = 1'(i % 2 == 0);
            din_data  = {$urandom, $urandom};
            step();
            if (bram_we) begin
                chk("s3_seq", 64'(bram_addr), 64'(seq));
                seq++;
            end
        end
        chk("s3_pulses", 64'(seq), 64'(DEPTH));
        chk("s3_nwr", 64'(m_writes - w0), 64'(DEPTH));

        // 4: abort after 6 writes
        din_valid = 1'b1;
        w0 = m_writes;
        arm(32'h1);
        for (int i = 0; i < 6; i++) begin
            din_data = {$urandom, $urandom};
            step();
        end
        ctrl_in = 32'h8;
        step();
        chk("s4_status", 64'(status_out), 64'h6);
        for (int i = 0; i < 5; i++) step();
        chk("s4_nwr", 64'(m_writes - w0), 64'h6);
        chk("s4_status_hold", 64'(status_out), 64'h6);

        // 6: async reset mid-capture
        arm(32'h1);
        for (int i = 0; i < 3; i++) begin
            din_data = {$urandom, $urandom};
            step();
        end
        #2;
        user_rst = 1'b1;
        #1;
        chk("s6_we", 64'(bram_we), 64'h0);
        chk("s6_addr", 64'(bram_addr), 64'h0);
        chk("s6_data", bram_data, 64'h0);
        chk("s6_status", 64'(status_out), 64'h0);
        model_reset();
        ctrl_in = 32'h0;
        @(posedge user_clk);
        @(negedge user_clk);
        user_rst = 1'b0;
        w0 = m_writes;
        for (int i = 0; i < 5; i++) step();
        chk("s6_nowr", 64'(m_writes - w0), 64'h0);
        ctrl_in = 32'h1;
        step();
        din_data = 64'h77;
        step();
        chk("s6_rearm_addr", 64'(bram_addr), 64'h0);
        chk("s6_rearm_data", bram_data, 64'h77);

        // random soak
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(15) == 0) begin
                ctrl_in = 32'($urandom) & 32'hFFFF_FFF7;
                if ($urandom_range(7) == 0) ctrl_in[3] = 1'b1;
            end
            din_valid = 1'($urandom);
            din_trig  = ($urandom_range(3) == 0);
            din_data  = {$urandom, $urandom};
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
